// File: rtl/mux8_32_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux8_32_rr_arbiter_pkg
// Shared constants and helpers for the 8-way round-robin arbiter that
// sequences the 32-bit 8:1 datapath mux.
//   NREQ  : number of requesters (8)
//   DW    : data word width (32)
//   SELW  : mux select width (3)
//   state_e : arbiter state encoding (ST_IDLE / ST_GRANT)
//   onehot8 : index -> one-hot grant vector
// ---------------------------------------------------------------------------
package mux8_32_rr_arbiter_pkg;

    localparam int NREQ = 8;
    localparam int DW   = 32;
    localparam int SELW = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic logic [NREQ-1:0] onehot8(input logic [SELW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux8_32.sv
// ---------------------------------------------------------------------------
// mux8_32
// Shared 32-bit 8:1 datapath multiplexer.
// Ports:
//   d0..d7 : input  [31:0] data words
//   sel    : input  [2:0]  select index
//   y      : output [31:0] selected word (combinational)
// ---------------------------------------------------------------------------
module mux8_32 (
    input  logic [31:0] d0,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  logic [31:0] d3,
    input  logic [31:0] d4,
    input  logic [31:0] d5,
    input  logic [31:0] d6,
    input  logic [31:0] d7,
    input  logic [2:0]  sel,
    output logic [31:0] y
);

    always_comb begin
        y = d0;
        case (sel)
            3'd0: y = d0;
            3'd1: y = d1;
            3'd2: y = d2;
            3'd3: y = d3;
            3'd4: y = d4;
            3'd5: y = d5;
            3'd6: y = d6;
            3'd7: y = d7;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/mux8_32_rr_arbiter_pick.sv
// ---------------------------------------------------------------------------
// rr_pick8
// Combinational rotating priority picker.
// Returns the first requester with req[k]=1 when scanning
// ptr, ptr+1, ..., 7, 0, ..., ptr-1.
// Ports:
//   ptr : input  [2:0] highest-priority position
//   req : input  [7:0] request vector
//   idx : output [2:0] chosen requester (0 when any=0)
//   any : output       at least one request present
// ---------------------------------------------------------------------------
module rr_pick8
    import mux8_32_rr_arbiter_pkg::*;
(
    input  logic [SELW-1:0] ptr,
    input  logic [NREQ-1:0] req,
    output logic [SELW-1:0] idx,
    output logic            any
);

    // rot[j] is the request that sits j positions after ptr, so a plain
    // lowest-index-first search over rot implements the rotating priority.
    logic [NREQ-1:0] rot;
    logic [SELW-1:0] off;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rot
            assign rot[gi] = req[SELW'(ptr + SELW'(gi))];
        end
    endgenerate

    // Descending scan so the lowest set position is the one left in off.
    always_comb begin
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = SELW'(k);
            end
        end
    end

    // 3-bit add wraps modulo 8, undoing the rotation.
    assign idx = (any) ? SELW'(ptr + off) : '0;
    assign any = |req;

endmodule

// File: rtl/mux8_32_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux8_32_rr_arbiter
// Round-robin arbiter and burst sequencer in front of the shared mux8_32.
// One requester is granted at a time; its word is streamed on a single
// valid/ready bus for at most MAX_BEATS beats before priority rotates.
// Parameters:
//   MAX_BEATS : beats per grant before forced rotation (1..255)
//   CW        : beat-counter width, 2**CW > MAX_BEATS
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   req[7:0]  : request lines, req[k] means ik holds a valid word
//   i0..i7    : requester data words
//   ack[7:0]  : one-hot, combinational; set for the requester whose word
//               transfers this cycle
//   out_data  : word of the selected requester
//   out_valid : combinational, busy & req[sel]
//   out_ready : downstream accepts a beat when out_valid & out_ready
//   gnt[7:0]  : registered one-hot grant, 0 when idle
//   sel[2:0]  : registered mux select (index of gnt)
//   busy      : registered, 1 while a grant is held
// ---------------------------------------------------------------------------
module mux8_32_rr_arbiter
    import mux8_32_rr_arbiter_pkg::*;
#(
    parameter int MAX_BEATS = 4,
    parameter int CW        = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [DW-1:0]   i0,
    input  logic [DW-1:0]   i1,
    input  logic [DW-1:0]   i2,
    input  logic [DW-1:0]   i3,
    input  logic [DW-1:0]   i4,
    input  logic [DW-1:0]   i5,
    input  logic [DW-1:0]   i6,
    input  logic [DW-1:0]   i7,
    output logic [NREQ-1:0] ack,
    output logic [DW-1:0]   out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NREQ-1:0] gnt,
    output logic [SELW-1:0] sel,
    output logic            busy
);

    // The limit fires when the beat taking cnt from MAX_BEATS-1 to
    // MAX_BEATS completes, so cnt itself never has to hold MAX_BEATS.
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

    state_e          state_q, state_d;
    logic [SELW-1:0] ptr_q,   ptr_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [SELW-1:0] sel_q,   sel_d;
    logic [NREQ-1:0] gnt_q,   gnt_d;
    logic            busy_q,  busy_d;

    logic            beat;
    logic            release_grant;
    logic [SELW-1:0] pick_ptr;
    logic [SELW-1:0] pick_idx;
    logic            pick_any;

    // ---------------------------------------------------------------
    // Datapath: existing mux, steered by the registered select
    // ---------------------------------------------------------------
    mux8_32 u_mux (
        .d0  (i0),
        .d1  (i1),
        .d2  (i2),
        .d3  (i3),
        .d4  (i4),
        .d5  (i5),
        .d6  (i6),
        .d7  (i7),
        .sel (sel_q),
        .y   (out_data)
    );

    // ---------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------
    assign out_valid = busy_q & req[sel_q];
    assign beat      = out_valid & out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ack
            assign ack[gi] = beat & (sel_q == SELW'(gi));
        end
    endgenerate

    // Release on a dropped request, or on the beat that exhausts the burst.
    // A stalled cycle has no beat, so the limit cannot fire then.
    assign release_grant = busy_q & (~req[sel_q] | (beat & (cnt_q == LAST_CNT)));

    // ---------------------------------------------------------------
    // Arbitration: one picker serves both the idle start and the
    // back-to-back re-grant. While granted, sel+1 is exactly the value
    // ptr will take on release, so the re-grant already sees the
    // rotated priority in the same cycle.
    // ---------------------------------------------------------------
    assign pick_ptr = (state_q == ST_GRANT) ? SELW'(sel_q + 1'b1) : ptr_q;

    rr_pick8 u_pick (
        .ptr (pick_ptr),
        .req (req),
        .idx (pick_idx),
        .any (pick_any)
    );

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    sel_d   = pick_idx;
                    gnt_d   = onehot8(pick_idx);
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end

            ST_GRANT: begin
                if (release_grant) begin
                    ptr_d = SELW'(sel_q + 1'b1);
                    cnt_d = '0;
                    if (pick_any) begin
                        // Covers a sole requester re-granted to itself.
                        sel_d = pick_idx;
                        gnt_d = onehot8(pick_idx);
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                    end
                end else if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mux8_32_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux8_32_rr_arbiter
// Directed bench for mux8_32_rr_arbiter with MAX_BEATS=4. Inputs change
// 1 time unit after each rising edge; outputs are sampled 1 unit later.
// Requester k always presents 32'h1000_000k.
// ---------------------------------------------------------------------------
module tb_mux8_32_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [7:0]  req;
    logic [31:0] i_w [8];
    logic [7:0]  ack;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  gnt;
    logic [2:0]  sel;
    logic        busy;

    int vec_count  = 0;
    int miscompares = 0;

    mux8_32_rr_arbiter #(
        .MAX_BEATS (4),
        .CW        (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .i0        (i_w[0]),
        .i1        (i_w[1]),
        .i2        (i_w[2]),
        .i3        (i_w[3]),
        .i4        (i_w[4]),
        .i5        (i_w[5]),
        .i6        (i_w[6]),
        .i7        (i_w[7]),
        .ack       (ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vec_count++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] ready_pat;
        int k;

        for (int n = 0; n < 8; n++) i_w[n] = 32'h1000_0000 | 32'(n);
        rst_n     = 1'b0;
        req       = 8'h00;
        out_ready = 1'b0;

        // ---------------- reset state ----------------
        tick();
        chk8("rst_gnt",  gnt, 8'h00);
        chk8("rst_sel",  8'(sel), 8'd0);
        chk8("rst_busy", 8'(busy), 8'd0);
        chk8("rst_ack",  ack, 8'h00);
        chk8("rst_valid", 8'(out_valid), 8'd0);
        tick();
        rst_n = 1'b1;

        // ---------------- reset mid-grant ----------------
        req       = 8'h04;
        out_ready = 1'b1;
        tick();
        chk8("a_gnt",   gnt, 8'h04);
        chk8("a_sel",   8'(sel), 8'd2);
        chk8("a_busy",  8'(busy), 8'd1);
        chk8("a_ack",   ack, 8'h04);
        chk32("a_data", out_data, 32'h1000_0002);
        tick();            // beat 1
        tick();            // beat 2
        #2;
        rst_n = 1'b0;      // between edges
        #1;
        chk8("a_rst_gnt",   gnt, 8'h00);
        chk8("a_rst_busy",  8'(busy), 8'd0);
        chk8("a_rst_valid", 8'(out_valid), 8'd0);
        chk8("a_rst_ack",   ack, 8'h00);
        rst_n = 1'b1;
        tick();
        chk8("a_regnt", gnt, 8'h04);
        req = 8'h14;       // a competitor makes the rotation point visible
        for (int b = 0; b < 4; b++) begin
            chk8("a_burst_gnt", gnt, 8'h04);
            chk8("a_burst_ack", ack, 8'h04);
            tick();
        end
        chk8("a_rot_gnt", gnt, 8'h10);
        chk8("a_rot_sel", 8'(sel), 8'd4);
        req = 8'h00;
        #1;
        chk8("a_drop_valid", 8'(out_valid), 8'd0);
        chk8("a_drop_ack",   ack, 8'h00);
        tick();
        chk8("a_idle_busy", 8'(busy), 8'd0);
        chk8("a_idle_gnt",  gnt, 8'h00);

        // ---------------- round-robin fairness ----------------
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req       = 8'hFF;
        out_ready = 1'b1;
        tick();
        for (int g = 0; g < 9; g++) begin
            k = g % 8;
            for (int b = 0; b < 4; b++) begin
                chk8("rr_sel",   8'(sel), 8'(k));
                chk8("rr_gnt",   gnt, 8'(1 << k));
                chk8("rr_ack",   ack, 8'(1 << k));
                chk8("rr_busy",  8'(busy), 8'd1);
                chk32("rr_data", out_data, 32'h1000_0000 | 32'(k));
                tick();
            end
        end
        chk8("rr_end_sel", 8'(sel), 8'd1);

        // ---------------- wrap and skip ----------------
        req = 8'h20;       // requester 1 drops; pick from 2 finds 5
        #1;
        chk8("w_drop_ack", ack, 8'h00);
        tick();
        chk8("w_sel5", 8'(sel), 8'd5);
        req = 8'h03;       // 5 drops; ptr becomes 6, scan wraps to 0
        tick();
        chk8("w_sel0", 8'(sel), 8'd0);
        chk8("w_gnt0", gnt, 8'h01);
        for (int b = 0; b < 4; b++) begin
            chk8("w_burst_sel", 8'(sel), 8'd0);
            chk8("w_burst_ack", ack, 8'h01);
            tick();
        end
        chk8("w_sel1", 8'(sel), 8'd1);
        chk8("w_gnt1", gnt, 8'h02);
        req = 8'h00;
        tick();
        chk8("w_idle", 8'(busy), 8'd0);

        // ---------------- stall holds count (ptr=2) ----------------
        req       = 8'h08;
        out_ready = 1'b0;
        tick();
        chk8("s_gnt", gnt, 8'h08);
        ready_pat = 6'b111001;     // cycle order 1,0,0,1,1,1
        for (int c = 0; c < 6; c++) begin
            out_ready = ready_pat[c];
            if (c == 5) req = 8'h18;
            #1;
            chk8("s_ack", ack, ready_pat[c] ? 8'h08 : 8'h00);
            chk8("s_gnt_hold", gnt, 8'h08);
            tick();
        end
        chk8("s_rot_gnt", gnt, 8'h10);
        req       = 8'h00;
        out_ready = 1'b1;
        tick();
        chk8("s_idle", 8'(busy), 8'd0);

        // ---------------- early drop (ptr=5) ----------------
        req = 8'h40;
        tick();
        chk8("e_gnt6", gnt, 8'h40);
        req = 8'h00;
        tick();
        chk8("e_idle6", 8'(busy), 8'd0);
        req = 8'h21;       // ptr=7, scan 7,0 -> 0
        tick();
        chk8("e_gnt0", gnt, 8'h01);
        chk8("e_ack0", ack, 8'h01);
        tick();
        req = 8'h20;
        #1;
        chk8("e_drop_ack",   ack, 8'h00);
        chk8("e_drop_valid", 8'(out_valid), 8'd0);
        tick();
        chk8("e_sel5", 8'(sel), 8'd5);
        chk8("e_gnt5", gnt, 8'h20);
        chk32("e_data5", out_data, 32'h1000_0005);
        req = 8'h00;
        tick();
        chk8("e_idle", 8'(busy), 8'd0);

        // ---------------- sole requester (ptr=6) ----------------
        req = 8'h80;
        tick();
        for (int b = 0; b < 10; b++) begin
            chk8("so_gnt",   gnt, 8'h80);
            chk8("so_busy",  8'(busy), 8'd1);
            chk8("so_ack",   ack, 8'h80);
            chk32("so_data", out_data, 32'h1000_0007);
            tick();
        end
        req = 8'h00;
        tick();
        chk8("so_idle", 8'(busy), 8'd0);
        req = 8'h81;       // ptr wrapped 7->0, so 0 wins
        tick();
        chk8("so_wrap_gnt", gnt, 8'h01);
        chk8("so_wrap_sel", 8'(sel), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
